// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, ID branch flushes, imem waits.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W          = 5,
  parameter int unsigned LOAD_STALL_CYC = 1,
  parameter int unsigned MAX_WAIT       = 15,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             branch_taken,
  input  logic             imem_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             imem_timeout,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WaitW = 8;

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StLoadStall = 2'd1,
    StImemWait  = 2'd2,
    StIllegal   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic             load_use;
  logic             run_rules;

  assign load_use = ex_mem_read & (ex_rt != '0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  // A ready fetch ends the wait and the cycle is handled exactly like a RUN cycle.
  assign run_rules = (state_q == StRun) | ((state_q == StImemWait) & imem_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      rem_q     <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    if (run_rules) begin
      state_d = StRun;
      if (branch_taken) begin
        if (!imem_ready) begin
          state_d = StImemWait;
          wait_d  = WaitW'(1);
        end
      end else if (load_use) begin
        if (LOAD_STALL_CYC > 1) begin
          state_d = StLoadStall;
          rem_d   = 2'(LOAD_STALL_CYC - 1);
        end
      end else if (!imem_ready) begin
        state_d = StImemWait;
        wait_d  = WaitW'(1);
      end
    end else begin
      case (state_q)
        StLoadStall: begin
          rem_d = rem_q - 2'd1;
          if (rem_q == 2'd1) begin
            state_d = StRun;
          end
        end
        StImemWait: begin
          if (branch_taken) begin
            wait_d = WaitW'(1);
          end else if (wait_q == WaitW'(MAX_WAIT)) begin
            timeout_d = 1'b1;
            state_d   = StRun;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      if (run_rules) begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
        end else if (load_use) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
        end else if (!imem_ready) begin
          pc_hold    = 1'b1;
          ifid_flush = 1'b1;
        end
      end else begin
        case (state_q)
          StLoadStall: begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
          end
          StImemWait: begin
            pc_hold    = ~branch_taken;
            ifid_flush = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign ctrl_state   = state_q;
  assign imem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Bubbles only come from load-use; flush with PC released only from a taken branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (idex_bubble && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (ifid_flush && !pc_hold && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
